// File: rtl/btn_debounce_bank_pkg.sv
// Shared defaults and types for the push-button conditioner bank.
// Button index macros give the board buttons stable channel numbers.
`ifndef BTN_DEBOUNCE_BANK_PKG_SV
`define BTN_DEBOUNCE_BANK_PKG_SV

`define BTN_UP     0
`define BTN_DOWN   1
`define BTN_LEFT   2
`define BTN_RIGHT  3
`define BTN_CENTRE 4

package btn_debounce_bank_pkg;

    localparam int DEBOUNCE_DIV_BITS = 17;
    localparam int DEBOUNCE_STABLE   = 3;
    localparam int DEBOUNCE_HOLD     = 382;
    localparam int DEBOUNCE_REPEAT   = 76;

    typedef enum logic [2:0] {
        BTN_IDX_UP     = 3'd0,
        BTN_IDX_DOWN   = 3'd1,
        BTN_IDX_LEFT   = 3'd2,
        BTN_IDX_RIGHT  = 3'd3,
        BTN_IDX_CENTRE = 3'd4
    } btn_idx_e;

    // Per-channel conditioned outputs; strobes are single-cycle.
    typedef struct packed {
        logic rpt;
        logic rel;
        logic press;
        logic level;
    } btn_evt_t;

endpackage

`endif

// File: rtl/debounce_channel.sv
// One button: 2-flop sync, tick-sampled stability filter, press/release/repeat strobes.
// Latency 2 clocks + STABLE_CNT ticks; no backpressure, strobes are fire-and-forget.
module debounce_channel
    import btn_debounce_bank_pkg::*;
#(
    parameter int STABLE_CNT   = DEBOUNCE_STABLE,
    parameter int HOLD_TICKS   = DEBOUNCE_HOLD,
    parameter int REPEAT_TICKS = DEBOUNCE_REPEAT,
    parameter int CNT_W        = 9
) (
    input  logic     clk_100mhz,
    input  logic     rst,
    input  logic     btn_in,
    input  logic     sample_tick,
    output btn_evt_t evt
);

    localparam int SC_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    logic            sync_meta;
    logic            sync;
    logic            level_q;
    logic            press_q;
    logic            rel_q;
    logic            rpt_q;
    logic [SC_W-1:0] stable_cnt;
    logic            flip;

    assign flip = sample_tick && (sync != level_q) && (stable_cnt == SC_W'(STABLE_CNT - 1));

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync       <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_meta <= btn_in;
            sync      <= sync_meta;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            if (sample_tick) begin
                if (sync == level_q) begin
                    stable_cnt <= '0;
                end else if (flip) begin
                    level_q    <= sync;
                    stable_cnt <= '0;
                    press_q    <= sync;
                    rel_q      <= ~sync;
                end else begin
                    stable_cnt <= stable_cnt + SC_W'(1);
                end
            end
        end
    end

    generate
        if (REPEAT_TICKS > 0) begin : g_repeat
            logic [CNT_W-1:0] hold_cnt;

            // The flip tick is either the press edge or the release edge; both clear the hold count.
            always_ff @(posedge clk_100mhz) begin
                if (rst) begin
                    hold_cnt <= '0;
                    rpt_q    <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    if (!level_q || flip) begin
                        hold_cnt <= '0;
                    end else if (sample_tick) begin
                        if (hold_cnt == CNT_W'(HOLD_TICKS - 1)) begin
                            rpt_q    <= 1'b1;
                            hold_cnt <= CNT_W'(HOLD_TICKS - REPEAT_TICKS);
                        end else begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end
                end
            end
        end else begin : g_no_repeat
            assign rpt_q = 1'b0;
        end
    endgenerate

    assign evt.level = level_q;
    assign evt.press = press_q;
    assign evt.rel   = rel_q;
    assign evt.rpt   = rpt_q;

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of N_BTN debounce channels sharing one power-of-two sample-tick divider.
// Latency 2 clocks + STABLE_CNT ticks per channel; no backpressure, outputs are strobes/levels.
module btn_debounce_bank
    import btn_debounce_bank_pkg::*;
#(
    parameter int N_BTN        = 5,
    parameter int DIV_BITS     = DEBOUNCE_DIV_BITS,
    parameter int STABLE_CNT   = DEBOUNCE_STABLE,
    parameter int HOLD_TICKS   = DEBOUNCE_HOLD,
    parameter int REPEAT_TICKS = DEBOUNCE_REPEAT,
    parameter int CNT_W        = 9
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             sample_tick
);

    logic [DIV_BITS-1:0] div_cnt;
    logic                tick_q;

    // Tick registers the zero state of the divider, so it lands one clock after reset release.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            div_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            div_cnt <= div_cnt + DIV_BITS'(1);
            tick_q  <= (div_cnt == '0);
        end
    end

    assign sample_tick = tick_q;

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_ch
            btn_evt_t evt;

            debounce_channel #(
                .STABLE_CNT   (STABLE_CNT),
                .HOLD_TICKS   (HOLD_TICKS),
                .REPEAT_TICKS (REPEAT_TICKS),
                .CNT_W        (CNT_W)
            ) u_ch (
                .clk_100mhz  (clk_100mhz),
                .rst         (rst),
                .btn_in      (btn_in[i]),
                .sample_tick (tick_q),
                .evt         (evt)
            );

            assign btn_level[i]   = evt.level;
            assign btn_press[i]   = evt.press;
            assign btn_release[i] = evt.rel;
            assign btn_repeat[i]  = evt.rpt;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Scoreboard bench: expected strobes are queued with the tick index they must follow.
module tb_btn_debounce_bank;

    localparam int N           = 5;
    localparam int DIV_BITS    = 4;
    localparam int TICK_PERIOD = 16;
    localparam int EV_PRESS    = 0;
    localparam int EV_REL      = 1;
    localparam int EV_RPT      = 2;

    typedef struct {
        int kind;
        int ch;
        int tick;
    } ev_t;

    logic         clk_100mhz = 1'b0;
    logic         rst        = 1'b1;
    logic [N-1:0] btn_in     = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic         sample_tick;

    int  checks        = 0;
    int  errors        = 0;
    int  tick_cnt      = 0;
    int  cyc           = 0;
    int  last_tick_cyc = -1;
    ev_t exp_q[$];

    btn_debounce_bank #(
        .N_BTN        (N),
        .DIV_BITS     (DIV_BITS),
        .STABLE_CNT   (3),
        .HOLD_TICKS   (4),
        .REPEAT_TICKS (2),
        .CNT_W        (4)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .sample_tick (sample_tick)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, ticks=%0d", tick_cnt);
        $fatal(1, "watchdog expired");
    end

    // Monitor: counts ticks, checks tick spacing, and matches every strobe against the queue.
    always @(negedge clk_100mhz) begin : mon
        logic [N-1:0] s;
        ev_t          e;
        cyc++;
        if (rst) begin
            last_tick_cyc = -1;
        end else if (sample_tick) begin
            tick_cnt++;
            if (last_tick_cyc >= 0) begin
                checks++;
                if (cyc - last_tick_cyc !== TICK_PERIOD) begin
                    errors++;
                    $display("FAIL tick_period: got %0d clocks, want %0d", cyc - last_tick_cyc, TICK_PERIOD);
                end
            end
            last_tick_cyc = cyc;
        end
        for (int k = 0; k < 3; k++) begin
            s = (k == EV_PRESS) ? btn_press : (k == EV_REL) ? btn_release : btn_repeat;
            for (int c = 0; c < N; c++) begin
                if (s[c] === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL strobe_unexpected: kind=%0d ch=%0d at tick %0d, none expected", k, c, tick_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind !== k || e.ch !== c || e.tick !== tick_cnt) begin
                            errors++;
                            $display("FAIL strobe_match: got kind=%0d ch=%0d tick=%0d, want kind=%0d ch=%0d tick=%0d",
                                     k, c, tick_cnt, e.kind, e.ch, e.tick);
                        end
                    end
                end
            end
        end
    end

    task automatic push_ev(input int kind, input int ch, input int tick);
        ev_t e;
        e.kind = kind;
        e.ch   = ch;
        e.tick = tick;
        exp_q.push_back(e);
    endtask

    // Returns at negedge+1 inside the cycle where tick number 'target' is high.
    task automatic wait_tick(input int target);
        int budget;
        budget = 64 * TICK_PERIOD;
        while (tick_cnt < target && budget > 0) begin
            @(negedge clk_100mhz);
            #1;
            budget--;
        end
        if (tick_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: reached tick %0d, want %0d", tick_cnt, target);
        end
    endtask

    task automatic next_tick(output int t);
        wait_tick(tick_cnt + 1);
        t = tick_cnt;
    endtask

    task automatic test_reset();
        int t1;
        rst    = 1'b1;
        btn_in = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_100mhz);
            #1;
            checks++;
            if ({btn_level, btn_press, btn_release, btn_repeat, sample_tick} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got level=%b press=%b rel=%b rpt=%b tick=%b, want all 0",
                         btn_level, btn_press, btn_release, btn_repeat, sample_tick);
            end
        end
        rst = 1'b0;
        @(posedge clk_100mhz);
        #1;
        checks++;
        if (sample_tick !== 1'b1) begin
            errors++;
            $display("FAIL first_tick: got %b, want 1 one clock after reset release", sample_tick);
        end
        @(negedge clk_100mhz);
        #1;
        t1 = tick_cnt;
        for (int c = 0; c < N; c++) push_ev(EV_PRESS, c, t1 + 3);
        wait_tick(t1 + 2);
        checks++;
        if (btn_level !== 5'b00000) begin
            errors++;
            $display("FAIL reset_early_level: got %b, want 00000 before 3rd tick", btn_level);
        end
        wait_tick(t1 + 3);
        btn_in = '0;
        for (int c = 0; c < N; c++) push_ev(EV_REL, c, t1 + 6);
        @(negedge clk_100mhz);
        #1;
        checks++;
        if (btn_level !== 5'b11111) begin
            errors++;
            $display("FAIL reset_press_level: got %b, want 11111", btn_level);
        end
        wait_tick(t1 + 6);
        @(negedge clk_100mhz);
        #1;
        checks++;
        if (btn_level !== 5'b00000) begin
            errors++;
            $display("FAIL reset_release_level: got %b, want 00000", btn_level);
        end
    endtask

    task automatic test_clean_press();
        int t;
        next_tick(t);
        btn_in[0] = 1'b1;
        push_ev(EV_PRESS, 0, t + 3);
        wait_tick(t + 2);
        checks++;
        if (btn_level !== 5'b00000) begin
            errors++;
            $display("FAIL clean_pre_level: got %b, want 00000", btn_level);
        end
        wait_tick(t + 3);
        btn_in[0] = 1'b0;
        push_ev(EV_REL, 0, t + 6);
        @(negedge clk_100mhz);
        #1;
        checks++;
        if (btn_level !== 5'b00001) begin
            errors++;
            $display("FAIL clean_level: got %b, want 00001", btn_level);
        end
        wait_tick(t + 7);
        checks++;
        if (btn_level !== 5'b00000) begin
            errors++;
            $display("FAIL clean_release_level: got %b, want 00000", btn_level);
        end
    endtask

    task automatic test_glitch();
        int t;
        next_tick(t);
        btn_in[1] = 1'b1;
        wait_tick(t + 2);
        btn_in[1] = 1'b0;
        wait_tick(t + 5);
        checks++;
        if (btn_level !== 5'b00000) begin
            errors++;
            $display("FAIL glitch_level: got %b, want 00000", btn_level);
        end
        next_tick(t);
        btn_in[1] = 1'b1;
        push_ev(EV_PRESS, 1, t + 3);
        wait_tick(t + 3);
        btn_in[1] = 1'b0;
        push_ev(EV_REL, 1, t + 6);
        @(negedge clk_100mhz);
        #1;
        checks++;
        if (btn_level !== 5'b00010) begin
            errors++;
            $display("FAIL pulse3_level: got %b, want 00010", btn_level);
        end
        wait_tick(t + 7);
        checks++;
        if (btn_level !== 5'b00000) begin
            errors++;
            $display("FAIL pulse3_release_level: got %b, want 00000", btn_level);
        end
    endtask

    task automatic test_repeat();
        int t;
        next_tick(t);
        btn_in[2] = 1'b1;
        push_ev(EV_PRESS, 2, t + 3);
        push_ev(EV_RPT,   2, t + 7);
        push_ev(EV_RPT,   2, t + 9);
        push_ev(EV_RPT,   2, t + 11);
        push_ev(EV_REL,   2, t + 13);
        wait_tick(t + 8);
        checks++;
        if (btn_level !== 5'b00100) begin
            errors++;
            $display("FAIL repeat_level: got %b, want 00100", btn_level);
        end
        wait_tick(t + 10);
        btn_in[2] = 1'b0;
        wait_tick(t + 16);
        checks++;
        if (btn_level !== 5'b00000) begin
            errors++;
            $display("FAIL repeat_release_level: got %b, want 00000", btn_level);
        end
    endtask

    task automatic test_simul_reset();
        int t;
        int t2;
        next_tick(t);
        btn_in[4:3] = 2'b11;
        push_ev(EV_PRESS, 3, t + 3);
        push_ev(EV_PRESS, 4, t + 3);
        wait_tick(t + 4);
        checks++;
        if (btn_level !== 5'b11000) begin
            errors++;
            $display("FAIL simul_level: got %b, want 11000", btn_level);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_100mhz);
            #1;
            checks++;
            if ({btn_level, btn_release, sample_tick} !== '0) begin
                errors++;
                $display("FAIL midpress_reset: got level=%b rel=%b tick=%b, want all 0",
                         btn_level, btn_release, sample_tick);
            end
        end
        rst = 1'b0;
        @(negedge clk_100mhz);
        #1;
        checks++;
        if (sample_tick !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_tick: got %b, want 1", sample_tick);
        end
        t2 = tick_cnt;
        push_ev(EV_PRESS, 3, t2 + 3);
        push_ev(EV_PRESS, 4, t2 + 3);
        wait_tick(t2 + 3);
        btn_in[4:3] = 2'b00;
        push_ev(EV_REL, 3, t2 + 6);
        push_ev(EV_REL, 4, t2 + 6);
        @(negedge clk_100mhz);
        #1;
        checks++;
        if (btn_level !== 5'b11000) begin
            errors++;
            $display("FAIL fresh_press_level: got %b, want 11000", btn_level);
        end
        wait_tick(t2 + 7);
        checks++;
        if (btn_level !== 5'b00000) begin
            errors++;
            $display("FAIL fresh_release_level: got %b, want 00000", btn_level);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_repeat();
        test_simul_reset();
        repeat (4) @(negedge clk_100mhz);
        #1;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debounce_bank.md
Name: btn_debounce_bank

Overview:
Parametrised multi-channel push-button conditioner: one shared sample-tick divider feeding N independent debounce channels. Each channel has:
- a 2-flop synchroniser
- an N-consecutive-sample stability filter
- one-cycle press/release strobes
- optional hold-to-auto-repeat strobes

Sits between the board button pins and the game/cursor control FSMs. Replaces per-button single-level debouncers.

Parameters:
N_BTN, 5, number of independent button channels
DIV_BITS, 17, sample-tick divider width; tick period = 2^DIV_BITS clocks (≈763 Hz at 100 MHz)
STABLE_CNT, 3, consecutive opposing samples required to flip a channel's level (≥1)
HOLD_TICKS, 382, ticks a level must stay high before the first repeat strobe (≈0.5 s)
REPEAT_TICKS, 76, ticks between subsequent repeat strobes (≈0.1 s); 0 disables repeat entirely
CNT_W, 9, width of hold/repeat counters; must hold max(HOLD_TICKS, REPEAT_TICKS)

Ports:
clk_100mhz  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
btn_in  input  N_BTN  raw asynchronous button pins, 1 = pressed
btn_level  output  N_BTN  debounced level per channel
btn_press  output  N_BTN  one-clock strobe on debounced 0→1
btn_release  output  N_BTN  one-clock strobe on debounced 1→0
btn_repeat  output  N_BTN  one-clock auto-repeat strobe while held
sample_tick  output  1  shared divider tick, for test and debug

Behaviour:
- Reset (rst=1 at a clk_100mhz edge):
  - Clears divider, tick, synchroniser flops, stable counters, hold counters and all outputs to 0.
  - Reset mid-press: level returns to 0 with no release strobe. After rst deasserts, a still-held button re-qualifies as a fresh press.
- Divider:
  - DIV_BITS free-running counter increments every clock.
  - sample_tick is registered and high for exactly one clock when the counter value is 0.
  - First tick appears 1 clock after rst deasserts; period is 2^DIV_BITS thereafter. Counter wraps naturally.
- Synchroniser: btn_in passes through 2 flops every clock, independent of the tick. The filter uses only the second flop (sync).
- Filter (per channel, acts only on cycles with sample_tick=1):
  - If sync == btn_level: stable counter := 0.
  - Else, if stable counter == STABLE_CNT-1: btn_level := sync, stable counter := 0, and assert btn_press (new level 1) or btn_release (new level 0) on the same edge.
  - Otherwise stable counter increments.
  - Any agreeing sample resets the count, so glitches shorter than STABLE_CNT ticks are rejected.
- Strobes:
  - press/release/repeat are registered, high for exactly one clock, and deasserted on the next clock.
  - Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Repeat (per channel, REPEAT_TICKS > 0 only):
  - Hold counter clears on the press edge and whenever btn_level=0.
  - On each tick with btn_level=1 it increments.
  - When it reaches HOLD_TICKS: btn_repeat pulses and the counter reloads to HOLD_TICKS-REPEAT_TICKS, giving subsequent strobes every REPEAT_TICKS ticks.
  - press and repeat never coincide.
  - A release clears the counter with no repeat on the release cycle.
  - If REPEAT_TICKS=0, btn_repeat is tied 0 and the hold logic is not generated.
- Latency: btn_in edge → level/press = 2 sync clocks + STABLE_CNT ticks (worst case + 1 tick period of phase).

Decomposition:
- Shared package/header holds default constants:
  - DEBOUNCE_DIV_BITS=17
  - DEBOUNCE_STABLE=3
  - DEBOUNCE_HOLD=382
  - DEBOUNCE_REPEAT=76
  - a macro for button index names (UP, DOWN, LEFT, RIGHT, CENTRE = 0..4)
- One sub-module, debounce_channel: synchroniser, filter, strobes and repeat for a single bit, taking sample_tick as input. The top contains the divider and a generate loop of N_BTN channels.

Test Plan:
1. All scenarios run with DIV_BITS=4 (tick every 16 clocks), STABLE_CNT=3, HOLD_TICKS=4, REPEAT_TICKS=2.
2. Reset: assert rst for 3 clocks with btn_in=5'h1F → all outputs 0 during reset; first sample_tick 1 clock after release; press strobes follow 3 ticks later.
3. Clean press on ch0: btn_in[0]=1 held → btn_level[0] and a single btn_press[0] pulse on the 3rd qualifying tick; no other channel toggles.
4. Glitch rejection: ch1 high for 2 ticks then low → btn_level[1] stays 0, no press or release; repeat with a 3-tick pulse → press then release strobes.
5. Auto-repeat: hold ch2 for 12 ticks → press at tick 3, repeats at ticks 7, 9, 11 (relative to input change); release → single btn_release[2], repeat stops.
6. Simultaneous plus reset mid-press: ch3 and ch4 pressed in the same clock → both press strobes in the same cycle; assert rst while held → levels 0 with no release strobe; after rst deasserts → fresh press strobes after 3 ticks.
